// File: rtl/jtag_master_pkg.sv
// Shared types and constants for the JTAG initiator: FSM states, vector width
// and the command-length clamp.
package jtag_master_pkg;

    localparam int MAX_BITS = 32;
    localparam int LEN_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_RSP
    } state_e;

    // Lengths 33..63 collapse to a full 32-bit shift.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : len;
    endfunction

endpackage

// File: rtl/jtag_master_tck_gen.sv
// TCK half-period timer: load restarts a phase at the requested TCK level,
// phase_done marks the last main-clock cycle of that phase.
module jtag_master_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic level,
    input  logic run,
    output logic phase_done,
    output logic tck
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       tck_q, tck_d;

    assign phase_done = run && (cnt_q == LAST);
    assign tck        = tck_q;

    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (load) begin
            cnt_d = '0;
            tck_d = level;
        end else if (run && !phase_done) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

endmodule

// File: rtl/jtag_master.sv
// JTAG initiator: shifts up to 32 TMS/TDI bits per command out on TCK and
// returns the TDO bits captured at the end of each TCK high phase.
module jtag_master
    import jtag_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                io_mainClk,
    input  logic                io_asyncReset,
    input  logic                io_cmd_valid,
    output logic                io_cmd_ready,
    input  logic [LEN_W-1:0]    io_cmd_payload_length,
    input  logic [MAX_BITS-1:0] io_cmd_payload_tms,
    input  logic [MAX_BITS-1:0] io_cmd_payload_tdi,
    output logic                io_rsp_valid,
    input  logic                io_rsp_ready,
    output logic [MAX_BITS-1:0] io_rsp_payload_tdo,
    output logic                io_jtag_tck,
    output logic                io_jtag_tms,
    output logic                io_jtag_tdi,
    input  logic                io_jtag_tdo,
    output logic                io_busy
);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [4:0]          idx_q, idx_d;
    logic [MAX_BITS-1:0] tms_vec_q, tms_vec_d;
    logic [MAX_BITS-1:0] tdi_vec_q, tdi_vec_d;
    logic [MAX_BITS-1:0] tdo_q, tdo_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                tdo_meta_q, tdo_sync_q;
    logic                load, level, run, phase_done;

    assign run = (state_q == ST_LOW) || (state_q == ST_HIGH);

    jtag_master_tck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tck_gen (
        .clk       (io_mainClk),
        .rst       (io_asyncReset),
        .load      (load),
        .level     (level),
        .run       (run),
        .phase_done(phase_done),
        .tck       (io_jtag_tck)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        tms_vec_d   = tms_vec_q;
        tdi_vec_d   = tdi_vec_q;
        tdo_d       = tdo_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        rsp_valid_d = rsp_valid_q;
        load        = 1'b0;
        level       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (io_cmd_valid) begin
                    len_d     = clamp_len(io_cmd_payload_length);
                    tms_vec_d = io_cmd_payload_tms;
                    tdi_vec_d = io_cmd_payload_tdi;
                    tdo_d     = '0;
                    idx_d     = '0;
                    if (len_d == '0) begin
                        state_d     = ST_RSP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                        tms_d   = io_cmd_payload_tms[0];
                        tdi_d   = io_cmd_payload_tdi[0];
                        load    = 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (phase_done) begin
                    state_d = ST_HIGH;
                    load    = 1'b1;
                    level   = 1'b1;
                end
            end
            ST_HIGH: begin
                // The target moved TDO on the previous fall, so it has long settled here.
                if (phase_done) begin
                    tdo_d[idx_q] = tdo_sync_q;
                    load         = 1'b1;
                    if ({1'b0, idx_q} == len_q - 6'd1) begin
                        state_d     = ST_RSP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                        idx_d   = idx_q + 5'd1;
                        tms_d   = tms_vec_q[idx_q + 5'd1];
                        tdi_d   = tdi_vec_q[idx_q + 5'd1];
                    end
                end
            end
            ST_RSP: begin
                if (io_rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            tdo_q       <= '0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            tdo_meta_q  <= 1'b0;
            tdo_sync_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            tdo_q       <= tdo_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            rsp_valid_q <= rsp_valid_d;
            tdo_meta_q  <= io_jtag_tdo;
            tdo_sync_q  <= tdo_meta_q;
        end
    end

    // Command vectors are only read while a shift is in flight, so they need no reset.
    always_ff @(posedge io_mainClk) begin
        tms_vec_q <= tms_vec_d;
        tdi_vec_q <= tdi_vec_d;
    end

    assign io_cmd_ready       = (state_q == ST_IDLE);
    assign io_busy            = (state_q != ST_IDLE);
    assign io_rsp_valid       = rsp_valid_q;
    assign io_rsp_payload_tdo = tdo_q;
    assign io_jtag_tms        = tms_q;
    assign io_jtag_tdi        = tdi_q;

endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- JTAG initiator that drives TCK/TMS/TDI into a JTAG target and captures TDO; it is the other end of the Murax SoC debug JTAG port.
- Accepts shift commands of up to 32 bits, each with per-bit TMS and TDI vectors, over a valid/ready stream.
- Returns the captured TDO bits over a second valid/ready stream.
- Used on-board or in simulation to drive the VexRiscv debug TAP without an external probe.

Parameters:
- CLK_DIV, 4, TCK half-period in io_mainClk cycles; legal range 2..255.
- MAX_BITS, 32, width of the TMS/TDI/TDO vectors; fixed at 32 for this revision.

Ports:
- io_mainClk  in  1  system clock.
- io_asyncReset  in  1  asynchronous, active-high reset.
- io_cmd_valid  in  1  command valid.
- io_cmd_ready  out  1  command accepted when valid&ready.
- io_cmd_payload_length  in  6  number of TCK pulses; 0 means none; 33..63 are clamped to 32.
- io_cmd_payload_tms  in  32  TMS value per bit, bit0 first.
- io_cmd_payload_tdi  in  32  TDI value per bit, bit0 first.
- io_rsp_valid  out  1  response valid.
- io_rsp_ready  in  1  response consumed when valid&ready.
- io_rsp_payload_tdo  out  32  captured TDO, bit i = bit i of the shift; bits >= length read 0.
- io_jtag_tck  out  1  JTAG clock.
- io_jtag_tms  out  1  JTAG mode select.
- io_jtag_tdi  out  1  JTAG data to target.
- io_jtag_tdo  in  1  JTAG data from target; asynchronous to io_mainClk.
- io_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, active-high) values: state IDLE, io_jtag_tck=0, io_jtag_tms=1, io_jtag_tdi=0, io_rsp_valid=0, io_rsp_payload_tdo=0, io_busy=0. io_cmd_ready is combinational (state==IDLE), so it is 1 out of reset.
- States are IDLE, LOW, HIGH and RSP.
- IDLE:
  - cmd fire latches tms, tdi and the clamped length, clears the tdo shadow and sets bit index i=0.
  - If length=0, go to RSP; otherwise go to LOW.
- LOW:
  - On entry, drive tms[i] and tdi[i] and set tck=0.
  - Hold for CLK_DIV cycles, then go to HIGH.
- HIGH:
  - tck=1 for CLK_DIV cycles; tms and tdi are unchanged.
  - On the last HIGH cycle, store the synchronized tdo into tdo[i].
  - Then, if i==length-1, set tck=0 and go to RSP; otherwise i++ and go to LOW.
- RSP:
  - io_rsp_valid=1 with the payload stable.
  - On valid&ready, go to IDLE; ready in the same cycle gives a 1-cycle RSP.
- TDO capture: io_jtag_tdo passes through a 2-flop synchronizer before sampling. The target changes TDO on TCK fall, so the sampled value is stable by 2*CLK_DIV cycles later (CLK_DIV >= 2).
- Latency:
  - Accept at cycle T: bit0 is driven at T+1, with tck=0.
  - First tck rise is at T+1+CLK_DIV.
  - io_rsp_valid rises at T+1+2*CLK_DIV*length; for length=0 it rises at T+1.
- Between commands: tck=0 and tms/tdi hold their last driven values. No TCK pulses are produced in IDLE or RSP.
- TCK duty cycle is exactly 50%, and every pulse has full width.
- cmd_valid while busy is not accepted; the payload must be held by the source per stream rules.
- Reset mid-shift: outputs return to reset values immediately (tck may truncate a pulse); the in-flight command and response are dropped.

Decomposition:
- Package jtag_master_pkg holds:
  - the state enum (IDLE/LOW/HIGH/RSP);
  - the constant MAX_BITS=32;
  - a length-clamp function.
- One sub-module, jtag_master_tck_gen: half-period counter producing a phase_done pulse and the tck level; it is reset by state entry.

Test Plan:
- CLK_DIV=4, length=1, tms=0, tdi=1, tdo tied 1, cmd at T:
  - tdi=1 from T+1;
  - tck rises at T+5 and falls at T+9;
  - rsp_valid at T+9 with tdo=0x00000001.
- Loopback tdo<=tdi delayed to TCK fall (target model), length=32, tdi=0xA5A5_1234, tms=0 → rsp tdo equals tdi shifted per model, exactly 32 tck rises counted.
- TMS sequence 5 ones then 0 (length=6, tms=0x1F) driving a TAP model → TAP reaches Run-Test/Idle; tms observed 1,1,1,1,1,0 at successive rises.
- length=0 → no tck edge; rsp_valid at T+1 with tdo=0. length=40 → exactly 32 pulses.
- rsp_ready held low 20 cycles → rsp_valid and payload stable, cmd_ready=0, tck stays 0; ready=1 → IDLE next cycle.
- Assert io_asyncReset mid-HIGH of bit 5 → same cycle tck=0, tms=1, rsp_valid=0, cmd_ready=1 after release; new command completes normally.
